pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
- Parametrised PWM ramp controller for the drive motor: steps the duty cycle from its current level toward a commanded target in fixed increments, holding each level for a programmable number of PWM periods.
- Supports acceleration, deceleration, retarget mid-ramp, controlled stop (ramp to 0) and emergency stop.
- Sits between the drive sequencer and the motor driver pin; runs entirely on clk_1mhz.

Parameters:
- PERIOD_US, 100, PWM period in clk_1mhz cycles (µs).
- DUTY_W, 7, width of duty values; must hold PERIOD_US.
- DUTY_STEP, 25, duty increment per ramp step, in µs of high time.
- STEP_PERIODS, 2500, PWM periods each ramp level is held (2500 × 100 µs = 250 ms).
- CNT_W, 14, width of the step-period counter; must hold STEP_PERIODS-1.

Ports:
- clk_1mhz  in  1  1 MHz system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  level or pulse; sampled each cycle; latches target_duty.
- target_duty  in  DUTY_W  requested high time per period; values > PERIOD_US clamp to PERIOD_US.
- stop  in  1  controlled stop: ramp down to 0, then idle.
- estop  in  1  emergency stop: immediate output off.
- pwm_signal  out  1  registered PWM output.
- busy  out  1  high in RAMP or HOLD.
- done  out  1  one-cycle pulse when a ramp or stop completes.
- at_target  out  1  cur_duty == latched target, not ramping.
- cur_duty  out  DUTY_W  duty currently applied.

Behaviour:
- Clock, reset and state: reset is synchronous, active-high; clock is clk_1mhz.
- Reset: state IDLE; all outputs 0; us_cnt, step_cnt and tgt cleared. Reset mid-operation gives pwm_signal=0 on the next edge.
- Priority, highest first: reset > estop > stop > start.
- Period generator:
  - us_cnt counts 0..PERIOD_US-1 and wraps; boundary = (us_cnt == PERIOD_US-1).
  - In RAMP/HOLD: pwm_signal <= (us_cnt < cur_duty), so there is 1 cycle of latency.
  - In IDLE: pwm_signal <= 0.
  - cur_duty changes only on the boundary cycle, so there are no runt pulses.
- IDLE:
  - start with clamped target ≠ 0: tgt <= clamp(target_duty); cur_duty <= min(DUTY_STEP, tgt); us_cnt <= 0; step_cnt <= 0; go to RAMP.
  - start with target 0: ignored.
  - stop: ignored.
- RAMP:
  - On each boundary, step_cnt increments.
  - When step_cnt == STEP_PERIODS-1 on a boundary, step_cnt <= 0 and:
    - if cur_duty ≠ tgt: cur_duty moves toward tgt by DUTY_STEP, saturating at tgt (no over- or undershoot, no wrap below 0).
    - if cur_duty == tgt: done pulses; go to HOLD. If tgt == 0 (stop path), go to IDLE instead.
  - The final level is held for a full STEP_PERIODS before done, so 0→100 with the defaults takes 4 × 250 ms = 1 s.
- HOLD:
  - Steady PWM at tgt; at_target = 1.
  - start with a new clamped target ≠ tgt: tgt updated; step_cnt <= 0; go to RAMP (accel or decel). The first step is applied at the first step expiry.
  - start with the same target: ignored.
- start in RAMP: tgt re-latched (retarget); step_cnt and cur_duty are not disturbed; direction is re-evaluated at the next step expiry.
- stop in RAMP/HOLD: tgt <= 0; state RAMP; ramps down by DUTY_STEP per level; done pulses when entering IDLE.
- estop, any state: next edge gives pwm_signal=0, cur_duty=0, tgt=0, state IDLE, busy=0. No done pulse.
- stop and start in the same cycle: stop wins; target_duty is discarded.
- busy = (state ≠ IDLE), registered. done is never high for 2 consecutive cycles.

Decomposition:
- Package pwm_ramp_pkg:
  - state enum IDLE/RAMP/HOLD.
  - Default constants PERIOD_US_DEF=100, DUTY_STEP_DEF=25, STEP_PERIODS_DEF=2500.
  - Clamp function.
- Sub-module pwm_period_gen:
  - Holds us_cnt, the comparator, and the boundary strobe.
  - Parametrised by PERIOD_US and DUTY_W.
  - Enable input; duty input is sampled on the boundary.

Test Plan (bench overrides STEP_PERIODS=2, PERIOD_US=100, DUTY_STEP=25):
1. Reset, then start with target 100 → pwm high 25/50/75/100 µs per period, 2 periods each; done pulses once, 800 cycles after RAMP entry; busy=1; at_target=1 afterwards.
2. In HOLD at 100, start with target 30 → levels 75, 50, 30 (saturated, not 25); done once; cur_duty=30; pwm high exactly 30 of 100 cycles.
3. Mid-ramp at cur_duty 50 (target 100), assert stop → levels 25, then 0 held 2 periods; done; state IDLE; pwm_signal=0; start with target 0 ignored.
4. estop during 75% level → pwm_signal=0, cur_duty=0, busy=0 on the next edge; no done pulse; a subsequent start restarts at 25.
5. Start with target 120 → clamped, ends at cur_duty=100. Start and stop together in HOLD → stop wins, ramps to 0.
6. Synchronous reset asserted mid-period at duty 50 → all outputs 0 on the next edge; no PWM until a new start.

Source files
------------

// File: rtl/pwm_ramp_pkg.sv
// Shared types, default timing constants and the duty clamp for the drive-motor PWM ramp controller.
package pwm_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int PERIOD_US_DEF    = 100;
  localparam int DUTY_STEP_DEF    = 25;
  localparam int STEP_PERIODS_DEF = 2500;

  function automatic int unsigned clamp_duty(input int unsigned val, input int unsigned lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/pwm_period_gen.sv
// PWM period counter, boundary strobe and registered duty comparator.
// Output is one cycle behind us_cnt; disabling parks the counter at 0 and forces the output low.
module pwm_period_gen #(
  parameter int PERIOD_US = 100,
  parameter int DUTY_W    = 7
) (
  input  logic              clk_1mhz,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_signal,
  output logic              boundary
);

  localparam int US_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam logic [US_W-1:0] US_LAST = US_W'(PERIOD_US - 1);

  logic [US_W-1:0] us_cnt;

  assign boundary = enable && (us_cnt == US_LAST);

  // The controller only moves duty on the boundary cycle, so comparing
  // against it directly never produces a runt pulse.
  always_ff @(posedge clk_1mhz) begin
    if (reset || !enable) begin
      us_cnt     <= '0;
      pwm_signal <= 1'b0;
    end else begin
      us_cnt     <= boundary ? '0 : us_cnt + US_W'(1);
      pwm_signal <= (32'(us_cnt) < 32'(duty));
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the motor PWM duty toward a commanded target one DUTY_STEP per STEP_PERIODS periods.
// Handles retarget mid-ramp, controlled stop (ramp to 0) and emergency stop (immediate off).
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter int PERIOD_US    = PERIOD_US_DEF,
  parameter int DUTY_W       = 7,
  parameter int DUTY_STEP    = DUTY_STEP_DEF,
  parameter int STEP_PERIODS = STEP_PERIODS_DEF,
  parameter int CNT_W        = 14
) (
  input  logic              clk_1mhz,
  input  logic              reset,
  input  logic              start,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              stop,
  input  logic              estop,
  output logic              pwm_signal,
  output logic              busy,
  output logic              done,
  output logic              at_target,
  output logic [DUTY_W-1:0] cur_duty
);

  localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(DUTY_STEP);
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_PERIODS - 1);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d, cur_d;
  logic [CNT_W-1:0]  step_cnt, step_d;
  logic              done_d;
  logic              boundary;
  logic [DUTY_W-1:0] tgt_in, first_lvl;

  assign tgt_in    = DUTY_W'(clamp_duty(32'(target_duty), PERIOD_US));
  assign first_lvl = (tgt_in < STEP_D) ? tgt_in : STEP_D;
  assign at_target = (state_q == HOLD) && (cur_duty == tgt_q);

  pwm_period_gen #(
    .PERIOD_US(PERIOD_US),
    .DUTY_W   (DUTY_W)
  ) u_period (
    .clk_1mhz  (clk_1mhz),
    .reset     (reset),
    .enable    ((state_q != IDLE) && !estop),
    .duty      (cur_duty),
    .pwm_signal(pwm_signal),
    .boundary  (boundary)
  );

  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      cur_duty <= '0;
      step_cnt <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      cur_duty <= cur_d;
      step_cnt <= step_d;
      done     <= done_d;
      busy     <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cur_d   = cur_duty;
    step_d  = step_cnt;
    done_d  = 1'b0;
    if (estop) begin
      state_d = IDLE;
      tgt_d   = '0;
      cur_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop && (tgt_in != '0)) begin
            tgt_d   = tgt_in;
            cur_d   = first_lvl;
            step_d  = '0;
            state_d = RAMP;
          end
        end
        RAMP: begin
          if (stop)       tgt_d = '0;
          else if (start) tgt_d = tgt_in;
          // Step decision uses the freshly latched target so a same-cycle
          // retarget or stop is honoured at this expiry.
          if (boundary) begin
            if (step_cnt == STEP_LAST) begin
              step_d = '0;
              if (cur_duty < tgt_d)
                cur_d = ((tgt_d - cur_duty) > STEP_D) ? cur_duty + STEP_D : tgt_d;
              else if (cur_duty > tgt_d)
                cur_d = ((cur_duty - tgt_d) > STEP_D) ? cur_duty - STEP_D : tgt_d;
              else begin
                done_d  = 1'b1;
                state_d = (tgt_d == '0) ? IDLE : HOLD;
              end
            end else begin
              step_d = step_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (stop) begin
            tgt_d   = '0;
            step_d  = '0;
            state_d = RAMP;
          end else if (start && (tgt_in != tgt_q)) begin
            tgt_d   = tgt_in;
            step_d  = '0;
            state_d = RAMP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with STEP_PERIODS=2, PERIOD_US=100, DUTY_STEP=25.
module tb_pwm_ramp_ctrl;

  logic       clk_1mhz = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       estop = 1'b0;
  logic [6:0] target_duty = '0;
  logic       pwm_signal, busy, done, at_target;
  logic [6:0] cur_duty;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] lv_q[$];
  int         done_cnt;
  int         last_chg_i;
  int         done_i;

  always #5 clk_1mhz = ~clk_1mhz;

  pwm_ramp_ctrl #(
    .PERIOD_US(100), .DUTY_W(7), .DUTY_STEP(25), .STEP_PERIODS(2), .CNT_W(14)
  ) dut (
    .clk_1mhz(clk_1mhz), .reset(reset), .start(start), .target_duty(target_duty),
    .stop(stop), .estop(estop), .pwm_signal(pwm_signal), .busy(busy), .done(done),
    .at_target(at_target), .cur_duty(cur_duty)
  );

  task automatic cyc();
    @(negedge clk_1mhz);
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
  endtask

  task automatic start_cmd(input logic [6:0] t);
    target_duty = t; start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic wait_cur(input logic [6:0] v, input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (cur_duty == v) begin found = 1'b1; break; end
      cyc();
    end
  endtask

  // Records each new cur_duty level until the first done pulse (or bound).
  task automatic record_until_done(input int bound);
    logic [6:0] prev;
    lv_q.delete(); done_cnt = 0; last_chg_i = 0; done_i = -1;
    prev = cur_duty;
    for (int i = 0; i < bound; i++) begin
      cyc();
      if (cur_duty != prev) begin lv_q.push_back(cur_duty); prev = cur_duty; last_chg_i = i; end
      if (done) begin done_cnt++; done_i = i; break; end
    end
  endtask

  function automatic logic [6:0] lv_at(input int k);
    return (lv_q.size() > k) ? lv_q[k] : 7'h7f;
  endfunction

  task automatic test_reset();
    reset = 1'b1; cyc(); cyc();
    vectors++;
    if ({pwm_signal, busy, done, at_target, cur_duty} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got pwm=%b busy=%b done=%b at=%b cur=%0d, want all 0",
               pwm_signal, busy, done, at_target, cur_duty);
    end
    reset = 1'b0; cyc();
  endtask

  task automatic test_accel();
    int hi[8];
    int exp_hi[8] = '{25, 25, 50, 50, 75, 75, 100, 100};
    int dcnt, dat;
    start_cmd(7'd100);
    vectors++;
    if (busy !== 1'b1 || cur_duty !== 7'd25) begin
      miscompares++;
      $display("FAIL accel_entry: busy=%b cur=%0d, want busy=1 cur=25", busy, cur_duty);
    end
    foreach (hi[p]) hi[p] = 0;
    dcnt = 0; dat = -1;
    for (int i = 0; i < 800; i++) begin
      cyc();
      if (pwm_signal) hi[i / 100]++;
      if (done) begin dcnt++; dat = i; end
    end
    for (int p = 0; p < 8; p++) begin
      vectors++;
      if (hi[p] !== exp_hi[p]) begin
        miscompares++;
        $display("FAIL accel_period%0d_high: got %0d cycles, want %0d", p, hi[p], exp_hi[p]);
      end
    end
    vectors++;
    if (dcnt !== 1 || dat !== 799) begin
      miscompares++;
      $display("FAIL accel_done: count=%0d at cycle %0d, want 1 at 800", dcnt, dat + 1);
    end
    vectors++;
    if (busy !== 1'b1 || at_target !== 1'b1 || cur_duty !== 7'd100) begin
      miscompares++;
      $display("FAIL accel_hold: busy=%b at=%b cur=%0d, want 1 1 100", busy, at_target, cur_duty);
    end
  endtask

  task automatic test_decel();
    int hcnt;
    start_cmd(7'd30);
    record_until_done(1500);
    vectors++;
    if (lv_q.size() !== 3 || lv_at(0) !== 7'd75 || lv_at(1) !== 7'd50 || lv_at(2) !== 7'd30) begin
      miscompares++;
      $display("FAIL decel_levels: n=%0d %0d/%0d/%0d, want 3 75/50/30",
               lv_q.size(), lv_at(0), lv_at(1), lv_at(2));
    end
    vectors++;
    if (done_cnt !== 1 || cur_duty !== 7'd30 || at_target !== 1'b1) begin
      miscompares++;
      $display("FAIL decel_done: done=%0d cur=%0d at=%b, want 1 30 1", done_cnt, cur_duty, at_target);
    end
    cyc();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL decel_done_width: done=%b one cycle later, want 0", done);
    end
    hcnt = 0;
    for (int i = 0; i < 100; i++) begin cyc(); if (pwm_signal) hcnt++; end
    vectors++;
    if (hcnt !== 30) begin
      miscompares++;
      $display("FAIL decel_pwm_high: got %0d of 100, want 30", hcnt);
    end
  endtask

  task automatic test_stop();
    bit f;
    do_reset();
    start_cmd(7'd100);
    wait_cur(7'd50, 1000, f);
    vectors++;
    if (!f) begin miscompares++; $display("FAIL stop_reach50: cur=%0d, want 50", cur_duty); end
    stop = 1'b1; cyc(); stop = 1'b0;
    record_until_done(1000);
    vectors++;
    if (lv_q.size() !== 2 || lv_at(0) !== 7'd25 || lv_at(1) !== 7'd0 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL stop_levels: n=%0d %0d/%0d done=%0d, want 2 25/0 done=1",
               lv_q.size(), lv_at(0), lv_at(1), done_cnt);
    end
    vectors++;
    if (done_i - last_chg_i !== 200) begin
      miscompares++;
      $display("FAIL stop_zero_hold: held %0d cycles, want 200", done_i - last_chg_i);
    end
    vectors++;
    if (busy !== 1'b0 || pwm_signal !== 1'b0 || at_target !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_idle: busy=%b pwm=%b at=%b, want 0 0 0", busy, pwm_signal, at_target);
    end
    start_cmd(7'd0);
    cyc(); cyc();
    vectors++;
    if (busy !== 1'b0 || cur_duty !== 7'd0) begin
      miscompares++;
      $display("FAIL stop_start0_ignored: busy=%b cur=%0d, want 0 0", busy, cur_duty);
    end
  endtask

  task automatic test_estop();
    bit f;
    int dcnt, bcnt;
    do_reset();
    start_cmd(7'd100);
    wait_cur(7'd75, 1000, f);
    repeat (10) cyc();
    vectors++;
    if (!f || pwm_signal !== 1'b1) begin
      miscompares++;
      $display("FAIL estop_pre: found75=%b pwm=%b, want 1 1", f, pwm_signal);
    end
    estop = 1'b1; cyc(); estop = 1'b0;
    vectors++;
    if (pwm_signal !== 1'b0 || cur_duty !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL estop_off: pwm=%b cur=%0d busy=%b done=%b, want 0 0 0 0",
               pwm_signal, cur_duty, busy, done);
    end
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < 300; i++) begin cyc(); if (done) dcnt++; if (busy) bcnt++; end
    vectors++;
    if (dcnt !== 0 || bcnt !== 0) begin
      miscompares++;
      $display("FAIL estop_quiet: done pulses=%0d busy cycles=%0d, want 0 0", dcnt, bcnt);
    end
    start_cmd(7'd100);
    vectors++;
    if (cur_duty !== 7'd25 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL estop_restart: cur=%0d busy=%b, want 25 1", cur_duty, busy);
    end
  endtask

  task automatic test_clamp_and_stop_wins();
    do_reset();
    start_cmd(7'd120);
    record_until_done(1500);
    vectors++;
    if (cur_duty !== 7'd100 || at_target !== 1'b1 || done_cnt !== 1 || lv_at(2) !== 7'd100) begin
      miscompares++;
      $display("FAIL clamp_120: cur=%0d at=%b done=%0d last=%0d, want 100 1 1 100",
               cur_duty, at_target, done_cnt, lv_at(2));
    end
    target_duty = 7'd50; start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    record_until_done(2000);
    vectors++;
    if (lv_q.size() !== 4 || lv_at(3) !== 7'd0 || busy !== 1'b0 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL stop_beats_start: n=%0d last=%0d busy=%b done=%0d, want 4 0 0 1",
               lv_q.size(), lv_at(3), busy, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit f;
    int pcnt, bcnt;
    do_reset();
    start_cmd(7'd100);
    wait_cur(7'd50, 1000, f);
    repeat (10) cyc();
    reset = 1'b1; cyc();
    vectors++;
    if (!f || {pwm_signal, busy, done, at_target, cur_duty} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_mid: found50=%b pwm=%b busy=%b done=%b at=%b cur=%0d, want 1 then all 0",
               f, pwm_signal, busy, done, at_target, cur_duty);
    end
    reset = 1'b0;
    pcnt = 0; bcnt = 0;
    for (int i = 0; i < 300; i++) begin cyc(); if (pwm_signal) pcnt++; if (busy) bcnt++; end
    vectors++;
    if (pcnt !== 0 || bcnt !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: pwm high=%0d busy=%0d, want 0 0", pcnt, bcnt);
    end
  endtask

  initial begin
    cyc();
    test_reset();
    test_accel();
    test_decel();
    test_stop();
    test_estop();
    test_clamp_and_stop_wins();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
